// File: rtl/wb8_interconnect.sv
// 8-bit Wishbone interconnect: one master, NSLAVES slaves, base/mask decode,
// bus-error responses for unmapped addresses and ack watchdog, latched fault record.
module wb8_interconnect #(
  parameter int                      NSLAVES       = 8,
  parameter logic [NSLAVES*32-1:0]   ADR_BASES     = '0,
  parameter logic [NSLAVES*32-1:0]   ADR_MASKS     = '0,
  parameter int                      DEFAULT_SLAVE = NSLAVES,
  parameter int                      TIMEOUT       = 255
) (
  input  logic                   I_wb_clk,
  input  logic                   I_reset,
  input  logic                   I_wb_cyc,
  input  logic                   I_wb_stb,
  input  logic                   I_wb_we,
  input  logic [31:0]            I_wb_adr,
  output logic [7:0]             O_wb_dat,
  output logic                   O_wb_ack,
  output logic                   O_wb_stall,
  output logic                   O_wb_err,
  output logic [NSLAVES-1:0]     O_s_stb,
  input  logic [NSLAVES*8-1:0]   I_s_dat,
  input  logic [NSLAVES-1:0]     I_s_ack,
  input  logic [NSLAVES-1:0]     I_s_stall,
  output logic                   O_fault_valid,
  output logic [31:0]            O_fault_adr,
  output logic                   O_fault_timeout,
  output logic [7:0]             O_fault_count,
  input  logic                   I_fault_clr
);

  localparam int            IW          = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  localparam bit            HAS_DEFAULT = (DEFAULT_SLAVE >= 0) && (DEFAULT_SLAVE < NSLAVES);
  localparam logic [IW-1:0] DEFAULT_IDX = IW'(DEFAULT_SLAVE);
  localparam bit            TO_EN       = (TIMEOUT != 0);
  localparam logic [15:0]   TO_LIMIT    = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] sel_reg, sel_next;
  logic [15:0]   cnt_reg, cnt_next;
  logic          cause_reg, cause_next;
  logic          match_hit;
  logic [IW-1:0] match_idx;
  logic [7:0]    s_dat_arr [NSLAVES];
  logic          unused_we;

  assign unused_we = I_wb_we;

  generate
    for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_dat
      assign s_dat_arr[gi] = I_s_dat[gi*8 +: 8];
    end
  endgenerate

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((I_wb_adr & ADR_MASKS[32*i +: 32]) == (ADR_BASES[32*i +: 32] & ADR_MASKS[32*i +: 32])) begin
        match_hit = 1'b1;
        match_idx = IW'(i);
      end
    end
    if (!match_hit && HAS_DEFAULT) begin
      match_hit = 1'b1;
      match_idx = DEFAULT_IDX;
    end
  end

  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      cnt_reg   <= '0;
      cause_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      cnt_reg   <= cnt_next;
      cause_reg <= cause_next;
    end
  end

  // cnt counts unacked strobe cycles including the launch cycle, so the
  // error ack lands exactly TIMEOUT cycles after the strobe is first seen.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    cnt_next   = cnt_reg;
    cause_next = cause_reg;
    O_s_stb    = '0;
    O_wb_dat   = 8'h00;
    O_wb_ack   = 1'b0;
    O_wb_stall = 1'b0;
    O_wb_err   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (I_wb_cyc && I_wb_stb) begin
          if (!match_hit) begin
            state_next = ERR;
            cause_next = 1'b0;
          end else begin
            sel_next           = match_idx;
            cnt_next           = 16'd1;
            O_s_stb[match_idx] = 1'b1;
            O_wb_dat           = s_dat_arr[match_idx];
            O_wb_ack           = I_s_ack[match_idx];
            O_wb_stall         = I_s_stall[match_idx];
            if (!I_s_ack[match_idx]) begin
              if (TO_EN && (TIMEOUT == 1)) begin
                state_next = ERR;
                cause_next = 1'b1;
              end else begin
                state_next = BUSY;
              end
            end
          end
        end
      end
      BUSY: begin
        if (!I_wb_cyc) begin
          state_next = IDLE;
        end else begin
          O_s_stb[sel_reg] = I_wb_stb;
          O_wb_dat         = s_dat_arr[sel_reg];
          O_wb_ack         = I_s_ack[sel_reg];
          O_wb_stall       = I_s_stall[sel_reg];
          if (I_s_ack[sel_reg]) begin
            state_next = IDLE;
          end else begin
            if (cnt_reg != 16'hFFFF) cnt_next = cnt_reg + 16'd1;
            if (TO_EN && (cnt_reg == TO_LIMIT)) begin
              state_next = ERR;
              cause_next = 1'b1;
            end
          end
        end
      end
      ERR: begin
        O_wb_ack   = 1'b1;
        O_wb_err   = 1'b1;
        O_wb_dat   = 8'hFF;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Strobes and acks must vanish the moment reset rises, not at the next edge.
    if (I_reset) begin
      O_s_stb    = '0;
      O_wb_dat   = 8'h00;
      O_wb_ack   = 1'b0;
      O_wb_stall = 1'b0;
      O_wb_err   = 1'b0;
    end
  end

  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      O_fault_valid   <= 1'b0;
      O_fault_adr     <= '0;
      O_fault_timeout <= 1'b0;
      O_fault_count   <= '0;
    end else begin
      if (I_fault_clr) begin
        O_fault_valid   <= 1'b0;
        O_fault_adr     <= '0;
        O_fault_timeout <= 1'b0;
        O_fault_count   <= '0;
      end
      // A fault coinciding with a clear is recorded on top of the cleared state.
      if (state_reg == ERR) begin
        if (!O_fault_valid || I_fault_clr) begin
          O_fault_valid   <= 1'b1;
          O_fault_adr     <= I_wb_adr;
          O_fault_timeout <= cause_reg;
        end
        if (I_fault_clr) O_fault_count <= 8'd1;
        else if (O_fault_count != 8'hFF) O_fault_count <= O_fault_count + 8'd1;
      end
    end
  end

endmodule
